// File: rtl/serial_right_shifter_if.sv
// serial_right_shifter_if: handshake and data bundle for the serial right shifter.
//   master: drives start/arith/shamt/in, observes result/busy/done (control unit side)
//   slave : the shifter itself
//   start  - request a shift, sampled only when the shifter is not busy
//   arith  - 1 = SRA (sign fill), 0 = SRL (zero fill), sampled with start
//   shamt  - shift amount 0..WIDTH-1, sampled with start
//   in     - operand, sampled with start
//   result - registered result of the last completed shift
//   busy   - operation in progress
//   done   - one-cycle completion pulse
interface serial_right_shifter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic             arith;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (output start, arith, shamt, in, input result, busy, done);
    modport slave  (input start, arith, shamt, in, output result, busy, done);
endinterface

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle SRL/SRA, one bit position per clock.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset; aborts any operation (no done)
//   bus   - serial_right_shifter_if.slave (start/arith/shamt/in in,
//           result/busy/done out)
// An accepted request takes shamt+1 cycles to reach DONE; done is high for
// exactly one cycle unless a new start is accepted in that same cycle.
// WIDTH and SHW must match the interface instance, with 2**SHW >= WIDTH.
module serial_right_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_right_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             fill;
    logic [WIDTH-1:0] result_q;
    logic             accept;

    // start is only honoured outside SHIFT; requests during SHIFT are dropped.
    assign accept = bus.start && (state != SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = SHIFT;
            SHIFT:   if (cnt == '0) state_n = DONE;
            DONE:    state_n = bus.start ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work     <= '0;
            cnt      <= '0;
            fill     <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            work <= bus.in;
            cnt  <= bus.shamt;
            fill <= bus.arith;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                // fill only replicates the current msb when arithmetic
                work <= {fill & work[WIDTH-1], work[WIDTH-1:1]};
                cnt  <= cnt - 1'b1;
            end else begin
                result_q <= work;
            end
        end
    end

    // Outputs are state-decoded or registered only.
    assign bus.result = result_q;
    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_serial_right_shifter.sv
// tb_serial_right_shifter: directed checks of the serial right shifter.
module tb_serial_right_shifter;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    serial_right_shifter_if #(.WIDTH(32), .SHW(5)) bus ();

    serial_right_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Drive a request so that the next rising edge is the accept edge E0.
    task automatic accept(input logic [31:0] i, input logic [4:0] s, input logic a);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = i;
        bus.shamt = s;
        bus.arith = a;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Count rising edges after E0 until done is seen (bounded), and the
    // number of sampled cycles with busy high. Returns at the negedge
    // inside the DONE cycle.
    task automatic wait_done(input int lat0, input int b0, output int lat, output int bcyc);
        lat  = lat0;
        bcyc = b0;
        @(negedge clk);
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] i, input logic [4:0] s,
                          input logic a, input logic [31:0] exp);
        int lat, bcyc;
        accept(i, s, a);
        wait_done(0, 0, lat, bcyc);
        chk({tag, "_lat"}, lat, 32'(s) + 32'd1);
        chk({tag, "_busy"}, bcyc, 32'(s) + 32'd1);
        chk({tag, "_res"}, bus.result, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int lat, bcyc, ndone;
        n_chk  = 0;
        n_pass = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.arith = 1'b0;
        bus.shamt = '0;
        bus.in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        reset = 1'b0;

        run_op("srl4", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000);
        run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        run_op("srl31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        run_op("pass0", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);
        run_op("sra_pos", 32'h7000_0000, 5'd4, 1'b1, 32'h0700_0000);

        // Ignored start: a second request during SHIFT must not disturb op.
        accept(32'h0000_0100, 5'd8, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'hFFFF_FFFF;
        bus.shamt = 5'd1;
        bus.arith = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(3, 3, lat, bcyc);
        chk("ign_lat", lat, 32'd9);
        chk("ign_busy", bcyc, 32'd9);
        chk("ign_res", bus.result, 32'h0000_0001);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("ign_one_done", ndone, 32'd0);

        // Asynchronous reset in the middle of a shift.
        accept(32'hAAAA_AAAA, 5'd16, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", bus.result, 32'd0);
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("arst_quiet", ndone, 32'd0);
        run_op("post_rst", 32'hAAAA_AAAA, 5'd16, 1'b1, 32'hFFFF_AAAA);

        // Back-to-back: second start accepted in the DONE cycle of the first.
        accept(32'h0000_0040, 5'd6, 1'b0);
        wait_done(0, 0, lat, bcyc);
        chk("b2b_a_lat", lat, 32'd7);
        chk("b2b_a_res", bus.result, 32'h0000_0001);
        bus.start = 1'b1;
        bus.in    = 32'h8000_0000;
        bus.shamt = 5'd1;
        bus.arith = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
        chk("b2b_nodone", {31'b0, bus.done}, 32'd0);
        chk("b2b_hold", bus.result, 32'h0000_0001);
        wait_done(0, 0, lat, bcyc);
        chk("b2b_b_lat", lat, 32'd2);
        chk("b2b_b_res", bus.result, 32'hC000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
